// File: rtl/memory_stage_pkg.sv
// Shared widths and the data-memory access FSM state type for the memory stage.
package memory_stage_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_REG_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

endpackage : memory_stage_pkg

// File: rtl/dff.sv
// Generic enabled register with synchronous active-low clear.
module dff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear on reset, otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule : dff

// File: rtl/dmem_access_fsm.sv
// Sequences one data-memory access per captured memory instruction.
module dmem_access_fsm
    import memory_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cap,
    input  logic       rd_en,
    input  logic       wr_en,
    input  logic       dmem_ready,
    output mem_state_e state,
    output logic       dmem_req,
    output logic       mem_busy,
    output logic       ld_en
);

    mem_state_e state_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a capture always decides the new state; otherwise ACCESS waits for ready.
    always_comb begin
        state_nxt = state;
        if (cap) begin
            state_nxt = (rd_en || wr_en) ? ST_ACCESS : ST_IDLE;
        end else if (state == ST_ACCESS && dmem_ready) begin
            state_nxt = ST_DONE;
        end
    end

    // Outputs: request is a pure state decode, busy drops in the ready cycle.
    always_comb begin
        dmem_req = 1'b0;
        mem_busy = 1'b0;
        ld_en    = 1'b0;
        if (state == ST_ACCESS) begin
            dmem_req = 1'b1;
            mem_busy = ~dmem_ready;
            ld_en    = dmem_ready & ~cap;
        end
    end

endmodule : dmem_access_fsm

// File: rtl/memory_stage.sv
// Memory pipeline stage: E->M register, data-memory handshake and writeback outputs.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [DATA_W-1:0] e_alu_result,
    input  logic [DATA_W-1:0] e_reg_rt,
    input  logic [REG_W-1:0]  e_rd,
    input  logic              e_mem_write_en,
    input  logic              e_mem_read_en,
    input  logic              e_reg_write_en,
    input  logic              e_reg_write_src,
    input  logic              e_halt,
    input  logic              mem_mem_forwarding,
    input  logic [DATA_W-1:0] w_reg_write_data,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] m_alu_result,
    output logic [DATA_W-1:0] m_mem_data,
    output logic [REG_W-1:0]  m_rd,
    output logic              m_reg_write_en,
    output logic              m_reg_write_src,
    output logic              m_halt,
    output logic              mem_busy
);

    localparam int unsigned PIPE_W = DATA_W + REG_W + 5;

    logic              cap;
    logic [PIPE_W-1:0] pipe_d;
    logic [PIPE_W-1:0] pipe_q;
    logic [DATA_W-1:0] alu_result;
    logic              mem_write_en;
    logic              mem_read_en;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] st_data_d;
    logic [DATA_W-1:0] ld_data;
    logic              ld_en;
    logic              ld_we;
    mem_state_e        state;

    // The stage advances only when neither the hazard unit nor the memory holds it.
    assign cap = ~stall & ~mem_busy;

    // Main E->M pipeline register.
    assign pipe_d = {e_alu_result, e_rd, e_mem_write_en, e_mem_read_en,
                     e_reg_write_en, e_reg_write_src, e_halt};

    dff #(.W(PIPE_W)) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (cap),
        .d     (pipe_d),
        .q     (pipe_q)
    );

    assign {alu_result, m_rd, mem_write_en, mem_read_en,
            m_reg_write_en, m_reg_write_src, m_halt} = pipe_q;

    // Store data reloads its own forwarded output while held, so a W-stage value
    // forwarded in the first access cycle survives W moving on.
    assign st_data_d = cap ? e_reg_rt : dmem_wdata;

    dff #(.W(DATA_W)) u_st_data (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (1'b1),
        .d     (st_data_d),
        .q     (st_data)
    );

    dmem_access_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .cap        (cap),
        .rd_en      (e_mem_read_en),
        .wr_en      (e_mem_write_en),
        .dmem_ready (dmem_ready),
        .state      (state),
        .dmem_req   (dmem_req),
        .mem_busy   (mem_busy),
        .ld_en      (ld_en)
    );

    // Only a genuine load (write has priority) parks its data while stalled.
    assign ld_we = ld_en & mem_read_en & ~mem_write_en;

    dff #(.W(DATA_W)) u_ld_data (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (ld_we),
        .d     (dmem_rdata),
        .q     (ld_data)
    );

    // Memory-side and writeback-side datapath.
    assign dmem_wdata   = mem_mem_forwarding ? w_reg_write_data : st_data;
    assign dmem_addr    = alu_result;
    assign dmem_we      = dmem_req & mem_write_en;
    assign m_alu_result = alu_result;
    assign m_mem_data   = (state == ST_ACCESS) ? dmem_rdata : ld_data;

endmodule : memory_stage

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage with hand-computed expectations.
module tb_memory_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [15:0] e_alu_result;
    logic [15:0] e_reg_rt;
    logic [3:0]  e_rd;
    logic        e_mem_write_en;
    logic        e_mem_read_en;
    logic        e_reg_write_en;
    logic        e_reg_write_src;
    logic        e_halt;
    logic        mem_mem_forwarding;
    logic [15:0] w_reg_write_data;
    logic [15:0] dmem_rdata;
    logic        dmem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] m_alu_result;
    logic [15:0] m_mem_data;
    logic [3:0]  m_rd;
    logic        m_reg_write_en;
    logic        m_reg_write_src;
    logic        m_halt;
    logic        mem_busy;

    int checks;
    int failures;

    memory_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .e_alu_result       (e_alu_result),
        .e_reg_rt           (e_reg_rt),
        .e_rd               (e_rd),
        .e_mem_write_en     (e_mem_write_en),
        .e_mem_read_en      (e_mem_read_en),
        .e_reg_write_en     (e_reg_write_en),
        .e_reg_write_src    (e_reg_write_src),
        .e_halt             (e_halt),
        .mem_mem_forwarding (mem_mem_forwarding),
        .w_reg_write_data   (w_reg_write_data),
        .dmem_rdata         (dmem_rdata),
        .dmem_ready         (dmem_ready),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .m_alu_result       (m_alu_result),
        .m_mem_data         (m_mem_data),
        .m_rd               (m_rd),
        .m_reg_write_en     (m_reg_write_en),
        .m_reg_write_src    (m_reg_write_src),
        .m_halt             (m_halt),
        .mem_busy           (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs changed after this return land on the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs before sampling (still far from the next edge).
    task automatic settle();
        #1;
    endtask

    task automatic set_e(input logic [15:0] alu, input logic [15:0] rt, input logic [3:0] rd,
                         input logic mw, input logic mr, input logic rw, input logic rsrc,
                         input logic halt);
        e_alu_result    = alu;
        e_reg_rt        = rt;
        e_rd            = rd;
        e_mem_write_en  = mw;
        e_mem_read_en   = mr;
        e_reg_write_en  = rw;
        e_reg_write_src = rsrc;
        e_halt          = halt;
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        rst_n              = 1'b0;
        stall              = 1'b0;
        mem_mem_forwarding = 1'b0;
        w_reg_write_data   = 16'h0;
        dmem_rdata         = 16'h0;
        dmem_ready         = 1'b0;
        set_e(16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        settle();
        check("rst_req",   32'(dmem_req), 32'h0);
        check("rst_busy",  32'(mem_busy), 32'h0);
        check("rst_alu",   32'(m_alu_result), 32'h0);
        check("rst_halt",  32'(m_halt), 32'h0);
        check("rst_mdata", 32'(m_mem_data), 32'h0);
        rst_n = 1'b1;

        // ALU passthrough, halt travels with it
        set_e(16'h1234, 16'h0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        settle();
        check("pt_alu",  32'(m_alu_result), 32'h1234);
        check("pt_rd",   32'(m_rd), 32'd5);
        check("pt_rwe",  32'(m_reg_write_en), 32'h1);
        check("pt_halt", 32'(m_halt), 32'h1);
        check("pt_req",  32'(dmem_req), 32'h0);
        check("pt_busy", 32'(mem_busy), 32'h0);

        // Load with a 3-cycle memory
        set_e(16'h0040, 16'h0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_e(16'h5555, 16'h0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("ld_c1_req",  32'(dmem_req), 32'h1);
        check("ld_c1_busy", 32'(mem_busy), 32'h1);
        check("ld_addr",    32'(dmem_addr), 32'h0040);
        check("ld_we",      32'(dmem_we), 32'h0);
        tick();
        settle();
        check("ld_c2_req",  32'(dmem_req), 32'h1);
        check("ld_c2_busy", 32'(mem_busy), 32'h1);
        check("ld_c2_alu",  32'(m_alu_result), 32'h0040);
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 16'hBEEF;
        settle();
        check("ld_c3_req",  32'(dmem_req), 32'h1);
        check("ld_c3_busy", 32'(mem_busy), 32'h0);
        check("ld_c3_data", 32'(m_mem_data), 32'hBEEF);
        check("ld_c3_src",  32'(m_reg_write_src), 32'h1);
        tick();
        dmem_ready = 1'b0;
        settle();
        check("ld_adv_alu", 32'(m_alu_result), 32'h5555);
        check("ld_adv_req", 32'(dmem_req), 32'h0);

        // Forwarded store over a 4-cycle access
        set_e(16'h0080, 16'h1111, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_e(16'h6666, 16'h0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        mem_mem_forwarding = 1'b1;
        w_reg_write_data   = 16'h2222;
        settle();
        check("st_c1_we",    32'(dmem_we), 32'h1);
        check("st_c1_wdata", 32'(dmem_wdata), 32'h2222);
        tick();
        mem_mem_forwarding = 1'b0;
        w_reg_write_data   = 16'h3333;
        settle();
        check("st_c2_we",    32'(dmem_we), 32'h1);
        check("st_c2_wdata", 32'(dmem_wdata), 32'h2222);
        tick();
        settle();
        check("st_c3_wdata", 32'(dmem_wdata), 32'h2222);
        check("st_c3_addr",  32'(dmem_addr), 32'h0080);
        tick();
        dmem_ready = 1'b1;
        settle();
        check("st_c4_we",    32'(dmem_we), 32'h1);
        check("st_c4_wdata", 32'(dmem_wdata), 32'h2222);
        check("st_c4_busy",  32'(mem_busy), 32'h0);
        tick();
        dmem_ready = 1'b0;
        settle();
        check("st_adv_alu", 32'(m_alu_result), 32'h6666);
        check("st_adv_req", 32'(dmem_req), 32'h0);

        // Load completing under an external stall
        set_e(16'h0090, 16'h0, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_e(16'h7777, 16'h0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stall = 1'b1;
        settle();
        check("sd_c1_req",  32'(dmem_req), 32'h1);
        check("sd_c1_busy", 32'(mem_busy), 32'h1);
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 16'h00A5;
        settle();
        check("sd_rdy_busy", 32'(mem_busy), 32'h0);
        check("sd_rdy_data", 32'(m_mem_data), 32'h00A5);
        tick();
        dmem_ready = 1'b0;
        dmem_rdata = 16'hFFFF;
        settle();
        check("sd_done_req",  32'(dmem_req), 32'h0);
        check("sd_done_data", 32'(m_mem_data), 32'h00A5);
        check("sd_done_alu",  32'(m_alu_result), 32'h0090);
        tick();
        settle();
        check("sd_norereq", 32'(dmem_req), 32'h0);
        check("sd_hold_rd", 32'(m_rd), 32'd9);
        stall = 1'b0;
        tick();
        settle();
        check("sd_adv_alu", 32'(m_alu_result), 32'h7777);
        check("sd_adv_rd",  32'(m_rd), 32'd2);

        // Store completing under stall must not disturb parked load data
        set_e(16'h00A0, 16'h4444, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_e(16'h8888, 16'h0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stall      = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = 16'h9999;
        settle();
        check("ss_we",    32'(dmem_we), 32'h1);
        check("ss_wdata", 32'(dmem_wdata), 32'h4444);
        tick();
        dmem_ready = 1'b0;
        settle();
        check("ss_done_req",  32'(dmem_req), 32'h0);
        check("ss_keep_ld",   32'(m_mem_data), 32'h00A5);
        stall = 1'b0;
        tick();
        settle();
        check("ss_adv_alu", 32'(m_alu_result), 32'h8888);

        // Back-to-back loads with immediate ready
        set_e(16'h0100, 16'h0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_e(16'h0102, 16'h0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        dmem_ready = 1'b1;
        dmem_rdata = 16'hAAAA;
        settle();
        check("bb1_req",  32'(dmem_req), 32'h1);
        check("bb1_addr", 32'(dmem_addr), 32'h0100);
        check("bb1_busy", 32'(mem_busy), 32'h0);
        check("bb1_data", 32'(m_mem_data), 32'hAAAA);
        tick();
        set_e(16'h9999, 16'h0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_rdata = 16'hBBBB;
        settle();
        check("bb2_req",  32'(dmem_req), 32'h1);
        check("bb2_addr", 32'(dmem_addr), 32'h0102);
        check("bb2_busy", 32'(mem_busy), 32'h0);
        check("bb2_data", 32'(m_mem_data), 32'hBBBB);
        tick();
        dmem_ready = 1'b0;
        settle();
        check("bb_end_req", 32'(dmem_req), 32'h0);
        check("bb_end_alu", 32'(m_alu_result), 32'h9999);

        // Both enables set: write wins
        set_e(16'h0200, 16'h5A5A, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_e(16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("both_we",    32'(dmem_we), 32'h1);
        check("both_wdata", 32'(dmem_wdata), 32'h5A5A);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;

        // Reset while an access is pending
        set_e(16'h0300, 16'h0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        set_e(16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("rm_pre_req", 32'(dmem_req), 32'h1);
        rst_n = 1'b0;
        tick();
        settle();
        check("rm_req",   32'(dmem_req), 32'h0);
        check("rm_busy",  32'(mem_busy), 32'h0);
        check("rm_alu",   32'(m_alu_result), 32'h0);
        check("rm_rd",    32'(m_rd), 32'h0);
        check("rm_halt",  32'(m_halt), 32'h0);
        check("rm_mdata", 32'(m_mem_data), 32'h0);
        rst_n = 1'b1;
        tick();
        settle();
        check("rm_post_req", 32'(dmem_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_memory_stage
